// File: rtl/wback_regfile_pkg.sv
// Shared defines for the writeback stage and the register file:
// writeback select codes, CSR addresses, trap cause codes, mstatus fields.
package wback_regfile_pkg;

  // Writeback result select
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_e;

  // Machine-mode CSR addresses
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

  // Trap cause codes
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // True for addresses backed by a real CSR register
  function automatic logic csr_implemented(input logic [31:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/wback_regfile_csr_file.sv
// Machine CSRs (mstatus, mtvec, mepc, mcause) plus ecall/mret trap updates.
// Trap updates override software writes only on the CSRs the trap touches.
module csr_file
  import wback_regfile_pkg::*;
#(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_wena_i,
  input  logic [31:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [31:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        ecall_i,
  input  logic [31:0] epc_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q,   mtvec_d;
  logic [31:0] mepc_q,    mepc_d;
  logic [31:0] mcause_q,  mcause_d;

  logic trap_ecall, trap_mret;
  logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;

  // Software write enables, masked where a trap owns the register this cycle
  always_comb begin
    trap_ecall = ecall_i;
    trap_mret  = mret_i & ~ecall_i;   // ecall wins when both are raised
    wr_mstatus = csr_wena_i && (csr_waddr_i == CSR_MSTATUS) && !(ecall_i || mret_i);
    wr_mtvec   = csr_wena_i && (csr_waddr_i == CSR_MTVEC);
    wr_mepc    = csr_wena_i && (csr_waddr_i == CSR_MEPC)   && !ecall_i;
    wr_mcause  = csr_wena_i && (csr_waddr_i == CSR_MCAUSE) && !ecall_i;
  end

  // Next-state for each CSR
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (trap_ecall) begin
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
      mepc_d                  = epc_i;
      mcause_d                = MCAUSE_ECALL_M;
    end else if (trap_mret) begin
      // MPP is left untouched: only M-mode exists here
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end else if (wr_mstatus) begin
      mstatus_d = csr_wdata_i;
    end
    if (wr_mtvec)  mtvec_d  = csr_wdata_i;
    if (wr_mepc)   mepc_d   = csr_wdata_i;
    if (wr_mcause) mcause_d = csr_wdata_i;
  end

  // CSR state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Read mux; a same-cycle write is forwarded only if it will actually land
  // (a write masked by a trap would otherwise show a value that never commits)
  always_comb begin
    csr_rdata_o = '0;
    unique case (csr_raddr_i)
      CSR_MSTATUS: csr_rdata_o = wr_mstatus ? csr_wdata_i : mstatus_q;
      CSR_MTVEC:   csr_rdata_o = wr_mtvec   ? csr_wdata_i : mtvec_q;
      CSR_MEPC:    csr_rdata_o = wr_mepc    ? csr_wdata_i : mepc_q;
      CSR_MCAUSE:  csr_rdata_o = wr_mcause  ? csr_wdata_i : mcause_q;
      default:     csr_rdata_o = '0;
    endcase
    if (rst_i) csr_rdata_o = (csr_raddr_i == CSR_MSTATUS) ? MSTATUS_RST : '0;
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: rtl/wback_regfile.sv
// Writeback register file: 32x32 GPRs with write bypass, a busy scoreboard
// that stalls reads of pending destinations, and the machine CSR block.
module wback_regfile
  import wback_regfile_pkg::*;
#(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter bit          SB_EN       = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wena_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic        csr_wena_i,
  input  logic [31:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o,
  input  logic [31:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic        issue_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        ecall_i,
  input  logic [31:0] epc_i,
  input  logic        mret_i,
  output logic        stall_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  localparam int NUM_RD = 2;

  logic [31:0] gpr_q [32];
  logic [31:0] busy_q, busy_d;

  logic [NUM_RD-1:0][4:0]  raddr;
  logic [NUM_RD-1:0][31:0] rdata;
  logic [NUM_RD-1:0]       stall_p;

  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;

  // GPR storage; x0 is never written so it stays 0 from reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (wena_i && (waddr_i != 5'd0)) begin
      gpr_q[waddr_i] <= wdata_i;
    end
  end

  // Scoreboard next-state: writeback clears first, issue sets last so a
  // simultaneous issue/writeback on the same rd leaves it pending
  always_comb begin
    busy_d = busy_q;
    if (wena_i) busy_d[waddr_i] = 1'b0;
    if (issue_i && (issue_rd_i != 5'd0)) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Per read port: bypass of same-cycle writeback and stall detection
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic hit_w;
    assign hit_w = wena_i && (waddr_i == raddr[p]) && (raddr[p] != 5'd0);

    // Read data with forwarding; forced to 0 while in reset
    always_comb begin
      rdata[p] = '0;
      if (!rst_i && (raddr[p] != 5'd0)) rdata[p] = hit_w ? wdata_i : gpr_q[raddr[p]];
    end

    // Pending operand unless its writeback is arriving this cycle
    always_comb begin
      stall_p[p] = busy_q[raddr[p]] && (raddr[p] != 5'd0) && !hit_w;
    end
  end

  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];
  assign stall_o  = SB_EN && !rst_i && (|stall_p);

  csr_file #(
    .MSTATUS_RST (MSTATUS_RST)
  ) u_csr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .csr_wena_i  (csr_wena_i),
    .csr_waddr_i (csr_waddr_i),
    .csr_wdata_i (csr_wdata_i),
    .csr_raddr_i (csr_raddr_i),
    .csr_rdata_o (csr_rdata_o),
    .ecall_i     (ecall_i),
    .epc_i       (epc_i),
    .mret_i      (mret_i),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o)
  );

endmodule
